// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and character classification for the text console.
package text_console_pkg;

    localparam int COLS          = 80;
    localparam int ROWS          = 25;
    localparam int WORDS_PER_ROW = 20;
    localparam int TOTAL_WORDS   = 500;

    localparam logic [31:0] SPACE_WORD = 32'h20202020;
    localparam logic [7:0]  CODE_LF    = 8'h0A;
    localparam logic [7:0]  CODE_FF    = 8'h0C;

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        CLR_ROW = 2'd2
    } state_t;

    function automatic logic isPrintable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console.sv
// Character-stream text console: packs accepted characters into 32-bit text RAM words
// and sweeps fill words over one row (LF / line wrap) or the whole screen (FF / reset).
module text_console #(
    parameter int         COLS      = text_console_pkg::COLS,
    parameter int         ROWS      = text_console_pkg::ROWS,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [8:0]  write_address,
    output logic [31:0] write_data,
    output logic        write_en,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);
    import text_console_pkg::*;

    localparam int          ROW_WORDS        = COLS / 4;
    localparam int          SCREEN_WORDS     = ROW_WORDS * ROWS;
    localparam logic [31:0] FILL_WORD        = {4{FILL_CHAR}};
    localparam logic [6:0]  LAST_COL         = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW         = 5'(ROWS - 1);
    localparam logic [8:0]  LAST_ROW_WORD    = 9'(ROW_WORDS - 1);
    localparam logic [8:0]  LAST_SCREEN_WORD = 9'(SCREEN_WORDS - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [8:0]  r_clrCount;
    logic [8:0]  w_nextClrCount;
    logic [6:0]  r_col;
    logic [6:0]  w_nextCol;
    logic [4:0]  r_row;
    logic [4:0]  w_nextRow;
    logic [31:0] r_shadow;
    logic [31:0] w_nextShadow;
    logic        r_writeEn;
    logic        w_nextWriteEn;
    logic [8:0]  r_writeAddr;
    logic [8:0]  w_nextWriteAddr;
    logic [31:0] r_writeData;
    logic [31:0] w_nextWriteData;

    logic        w_accept;
    logic        w_isPrintable;
    logic        w_isLf;
    logic        w_isFf;
    logic        w_lastCol;
    logic        w_clrDone;
    logic [4:0]  w_rowAdvanced;
    logic [8:0]  w_rowBase;
    logic [8:0]  w_charAddr;
    logic [31:0] w_merged;

    assign char_ready    = (r_state == IDLE);
    assign busy          = ~char_ready;
    assign write_en      = r_writeEn;
    assign write_address = r_writeAddr;
    assign write_data    = r_writeData;
    assign cursor_col    = r_col;
    assign cursor_row    = r_row;

    assign w_accept      = char_valid && char_ready;
    assign w_isPrintable = isPrintable(char_data);
    assign w_isLf        = (char_data == CODE_LF);
    assign w_isFf        = (char_data == CODE_FF);
    assign w_lastCol     = (r_col == LAST_COL);
    assign w_rowAdvanced = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
    assign w_rowBase     = 9'(r_row) * 9'(ROW_WORDS);
    assign w_charAddr    = w_rowBase + 9'(r_col[6:2]);
    // The shared counter terminates at a different count depending on which sweep is running.
    assign w_clrDone     = (r_state == CLR_ALL) ? (r_clrCount == LAST_SCREEN_WORD)
                                                : (r_clrCount == LAST_ROW_WORD);

    always_comb begin
        w_merged = r_shadow;
        case (r_col[1:0])
            2'd0:    w_merged[7:0]   = char_data;
            2'd1:    w_merged[15:8]  = char_data;
            2'd2:    w_merged[23:16] = char_data;
            default: w_merged[31:24] = char_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLR_ALL;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            CLR_ALL: begin
                if (w_clrDone) begin
                    w_nextState = IDLE;
                end
            end
            CLR_ROW: begin
                if (w_clrDone) begin
                    w_nextState = IDLE;
                end
            end
            IDLE: begin
                if (w_accept) begin
                    if (w_isFf) begin
                        w_nextState = CLR_ALL;
                    end else if (w_isLf || (w_isPrintable && w_lastCol)) begin
                        w_nextState = CLR_ROW;
                    end
                end
            end
            default: w_nextState = CLR_ALL;
        endcase
    end

    // Next values of every registered output; the write port only moves when a strobe is issued.
    always_comb begin
        w_nextWriteEn   = 1'b0;
        w_nextWriteAddr = r_writeAddr;
        w_nextWriteData = r_writeData;
        w_nextCol       = r_col;
        w_nextRow       = r_row;
        w_nextShadow    = r_shadow;
        w_nextClrCount  = r_clrCount;
        case (r_state)
            CLR_ALL: begin
                w_nextWriteEn   = 1'b1;
                w_nextWriteAddr = r_clrCount;
                w_nextWriteData = FILL_WORD;
                w_nextClrCount  = w_clrDone ? 9'd0 : r_clrCount + 9'd1;
            end
            CLR_ROW: begin
                w_nextWriteEn   = 1'b1;
                w_nextWriteAddr = w_rowBase + r_clrCount;
                w_nextWriteData = FILL_WORD;
                w_nextClrCount  = w_clrDone ? 9'd0 : r_clrCount + 9'd1;
            end
            IDLE: begin
                if (w_accept) begin
                    w_nextClrCount = 9'd0;
                    if (w_isPrintable) begin
                        w_nextWriteEn   = 1'b1;
                        w_nextWriteAddr = w_charAddr;
                        w_nextWriteData = w_merged;
                        if (w_lastCol) begin
                            w_nextCol    = 7'd0;
                            w_nextRow    = w_rowAdvanced;
                            w_nextShadow = FILL_WORD;
                        end else begin
                            w_nextCol    = r_col + 7'd1;
                            w_nextShadow = (r_col[1:0] == 2'd3) ? FILL_WORD : w_merged;
                        end
                    end else if (w_isLf) begin
                        w_nextCol    = 7'd0;
                        w_nextRow    = w_rowAdvanced;
                        w_nextShadow = FILL_WORD;
                    end else if (w_isFf) begin
                        w_nextCol    = 7'd0;
                        w_nextRow    = 5'd0;
                        w_nextShadow = FILL_WORD;
                    end
                end
            end
            default: begin
                w_nextClrCount = 9'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clrCount  <= 9'd0;
            r_col       <= 7'd0;
            r_row       <= 5'd0;
            r_shadow    <= SPACE_WORD;
            r_writeEn   <= 1'b0;
            r_writeAddr <= 9'd0;
            r_writeData <= SPACE_WORD;
        end else begin
            r_clrCount  <= w_nextClrCount;
            r_col       <= w_nextCol;
            r_row       <= w_nextRow;
            r_shadow    <= w_nextShadow;
            r_writeEn   <= w_nextWriteEn;
            r_writeAddr <= w_nextWriteAddr;
            r_writeData <= w_nextWriteData;
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Randomized and directed bench for text_console against a screen-level reference model
// (character grid, cursor and a queue of pending clear addresses).
module tb_text_console;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  charData;
    logic        charValid;
    logic        char_ready;
    logic [8:0]  write_address;
    logic [31:0] write_data;
    logic        write_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  screen [25][80];
    int          curRow;
    int          curCol;
    int          clearQ[$];
    logic [8:0]  lastAddr;
    logic [31:0] lastData;
    logic        lastAccepted = 1'b0;

    text_console dut (
        .clk           (clk),
        .reset         (reset),
        .char_data     (charData),
        .char_valid    (charValid),
        .char_ready    (char_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .cursor_col    (cursor_col),
        .cursor_row    (cursor_row),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] packWord(input int r, input int w);
        return {screen[r][4*w+3], screen[r][4*w+2], screen[r][4*w+1], screen[r][4*w]};
    endfunction

    task automatic modelClearRow(input int r);
        for (int c = 0; c < 80; c++) screen[r][c] = 8'h20;
        for (int w = 0; w < 20; w++) clearQ.push_back(r * 20 + w);
    endtask

    task automatic modelClearAll();
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 80; c++) screen[r][c] = 8'h20;
        for (int a = 0; a < 500; a++) clearQ.push_back(a);
    endtask

    task automatic modelReset();
        clearQ.delete();
        modelClearAll();
        curRow   = 0;
        curCol   = 0;
        lastAddr = 9'd0;
        lastData = 32'h20202020;
    endtask

    task automatic modelAccept(input logic [7:0] d, output logic we, output logic [8:0] addr,
                               output logic [31:0] data);
        we   = 1'b0;
        addr = 9'd0;
        data = 32'd0;
        if (d >= 8'h20 && d <= 8'h7E) begin
            screen[curRow][curCol] = d;
            we   = 1'b1;
            addr = 9'(curRow * 20 + curCol / 4);
            data = packWord(curRow, curCol / 4);
            if (curCol == 79) begin
                curCol = 0;
                curRow = (curRow + 1) % 25;
                modelClearRow(curRow);
            end else begin
                curCol++;
            end
        end else if (d == 8'h0A) begin
            curCol = 0;
            curRow = (curRow + 1) % 25;
            modelClearRow(curRow);
        end else if (d == 8'h0C) begin
            curCol = 0;
            curRow = 0;
            modelClearAll();
        end
    endtask

    // One clock cycle: drive, predict the edge from the model, then sample just after the edge.
    task automatic applyStimulus(input logic [7:0] d, input logic v);
        logic        accept;
        logic        expWe;
        logic [8:0]  expAddr;
        logic [31:0] expData;
        charData  = d;
        charValid = v;
        checkOutput("char_ready", {31'd0, char_ready}, {31'd0, clearQ.size() == 0});
        checkOutput("busy", {31'd0, busy}, {31'd0, clearQ.size() != 0});
        accept  = v && (clearQ.size() == 0);
        expWe   = 1'b0;
        expAddr = 9'd0;
        expData = 32'd0;
        if (accept) begin
            modelAccept(d, expWe, expAddr, expData);
        end else if (clearQ.size() != 0) begin
            expWe   = 1'b1;
            expAddr = 9'(clearQ.pop_front());
            expData = 32'h20202020;
        end
        @(posedge clk);
        #1;
        if (expWe) begin
            lastAddr = expAddr;
            lastData = expData;
        end
        checkOutput("write_en", {31'd0, write_en}, {31'd0, expWe});
        checkOutput("write_address", {23'd0, write_address}, {23'd0, lastAddr});
        checkOutput("write_data", write_data, lastData);
        checkOutput("cursor_col", {25'd0, cursor_col}, 32'(curCol));
        checkOutput("cursor_row", {27'd0, cursor_row}, 32'(curRow));
        lastAccepted = accept;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_write_en"}, {31'd0, write_en}, 32'd0);
        checkOutput({tag, "_write_address"}, {23'd0, write_address}, 32'd0);
        checkOutput({tag, "_write_data"}, write_data, 32'h20202020);
        checkOutput({tag, "_char_ready"}, {31'd0, char_ready}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_cursor_col"}, {25'd0, cursor_col}, 32'd0);
        checkOutput({tag, "_cursor_row"}, {27'd0, cursor_row}, 32'd0);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        charValid = 1'b0;
        charData  = 8'h00;
        #1;
        checkResetState("reset_async");
        @(posedge clk);
        #1;
        checkResetState("reset_held");
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic sendChar(input logic [7:0] d);
        logic willAccept;
        for (int i = 0; i < 1000; i++) begin
            willAccept = (clearQ.size() == 0);
            applyStimulus(d, 1'b1);
            if (willAccept) break;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0);
    endtask

    task automatic drain();
        while (clearQ.size() != 0) applyStimulus(8'h00, 1'b0);
    endtask

    function automatic logic [7:0] randChar();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 4) return 8'h0A;
        if (r == 4) return 8'h0C;
        if (r < 7) return 8'($urandom_range(0, 31));
        if (r < 10) return 8'($urandom_range(127, 255));
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        logic [7:0] d;
        logic       v;
        reset     = 1'b1;
        charValid = 1'b0;
        charData  = 8'h00;

        doReset();
        drain();
        idle(2);

        // "ABCDE" back-to-back from the home position.
        sendChar(8'h41);
        sendChar(8'h42);
        sendChar(8'h43);
        sendChar(8'h44);
        sendChar(8'h45);
        idle(2);

        // LF from row 3 column 10.
        sendChar(8'h0C);
        for (int i = 0; i < 3; i++) sendChar(8'h0A);
        for (int i = 0; i < 10; i++) sendChar(8'($urandom_range(32, 126)));
        sendChar(8'h0A);
        drain();
        idle(2);

        // Line wrap at the bottom-right corner.
        sendChar(8'h0C);
        for (int i = 0; i < 24; i++) sendChar(8'h0A);
        for (int i = 0; i < 79; i++) sendChar(8'($urandom_range(32, 126)));
        sendChar(8'h5A);
        drain();
        idle(2);

        // Ignored control and high codes, consumed back-to-back.
        sendChar(8'h07);
        sendChar(8'h80);
        idle(2);

        v = 1'b0;
        d = 8'h00;
        for (int i = 0; i < 800; i++) begin
            if (!(v && !lastAccepted)) begin
                v = ($urandom_range(0, 3) != 0);
                d = randChar();
            end
            applyStimulus(d, v);
        end
        drain();
        idle(2);

        // Reset in the middle of a full-screen clear.
        sendChar(8'h0C);
        while (clearQ.size() != 0 && clearQ[0] != 200) applyStimulus(8'h00, 1'b0);
        doReset();
        drain();
        idle(3);
        sendChar(8'h41);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
